// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared ALUOp encodings, control-vector type and width defaults for the ID/EX stage.
package id_ex_stage_pkg;
    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } aluop_e;

    typedef struct packed {
        logic   regwrite;
        logic   memtoreg;
        logic   memread;
        logic   memwrite;
        logic   alusrc;
        aluop_e aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{regwrite: 1'b0, memtoreg: 1'b0, memread: 1'b0,
                                      memwrite: 1'b0, alusrc: 1'b0, aluop: ALUOP_ADD};
endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// id_ex_stage_hazard_detect: combinational load-use detection between the load held in EX and the instruction in ID.
module id_ex_stage_hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              i_ex_valid,
    input  logic              i_ex_memread,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_id_valid,
    input  logic              i_id_use_rs1,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic              i_id_use_rs2,
    input  logic [REG_AW-1:0] i_id_rs2,
    output logic              o_stall
);
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    // x0 is never written, so a load targeting it cannot create a dependency
    assign o_stall   = i_ex_valid && i_ex_memread && (i_ex_rd != '0) && i_id_valid && (w_rs1_hit || w_rs2_hit);
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion, hold and flush.
// Define ID_EX_PERF_EN to add stall_cnt_o / flush_cnt_o performance counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic              id_regwrite_i,
    input  logic              id_memtoreg_i,
    input  logic              id_memread_i,
    input  logic              id_memwrite_i,
    input  logic              id_alusrc_i,
    input  logic [1:0]        id_aluop_i,
    input  logic [9:0]        id_funct_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [XLEN-1:0]   id_rs1data_i,
    input  logic [XLEN-1:0]   id_rs2data_i,
    input  logic [XLEN-1:0]   id_imm_i,
    output logic              ex_valid_o,
    output logic              ex_regwrite_o,
    output logic              ex_memtoreg_o,
    output logic              ex_memread_o,
    output logic              ex_memwrite_o,
    output logic              ex_alusrc_o,
    output logic [1:0]        ex_aluop_o,
    output logic [9:0]        ex_funct_o,
    output logic [REG_AW-1:0] ex_rs1_o,
    output logic [REG_AW-1:0] ex_rs2_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic [XLEN-1:0]   ex_rs1data_o,
    output logic [XLEN-1:0]   ex_rs2data_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic              stall_o
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);
    logic              r_valid;
    ctrl_t             r_ctrl;
    logic [9:0]        r_funct;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0]   r_rs1data;
    logic [XLEN-1:0]   r_rs2data;
    logic [XLEN-1:0]   r_imm;
    ctrl_t             w_id_ctrl;
    logic              w_stall;

    // an invalid ID slot must never carry live control into EX
    assign w_id_ctrl = id_valid_i ? '{regwrite: id_regwrite_i, memtoreg: id_memtoreg_i,
                                      memread: id_memread_i, memwrite: id_memwrite_i,
                                      alusrc: id_alusrc_i, aluop: aluop_e'(id_aluop_i)}
                                  : CTRL_BUBBLE;

    id_ex_stage_hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .i_ex_valid  (r_valid),
        .i_ex_memread(r_ctrl.memread),
        .i_ex_rd     (r_rd),
        .i_id_valid  (id_valid_i),
        .i_id_use_rs1(id_use_rs1_i),
        .i_id_rs1    (id_rs1_i),
        .i_id_use_rs2(id_use_rs2_i),
        .i_id_rs2    (id_rs2_i),
        .o_stall     (w_stall)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid   <= 1'b0;
            r_ctrl    <= CTRL_BUBBLE;
            r_funct   <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_rs1data <= '0;
            r_rs2data <= '0;
            r_imm     <= '0;
        end else if (!hold_i) begin
            if (flush_i || w_stall) begin
                r_valid   <= 1'b0;
                r_ctrl    <= CTRL_BUBBLE;
                r_funct   <= '0;
                r_rs1     <= '0;
                r_rs2     <= '0;
                r_rd      <= '0;
                r_rs1data <= '0;
                r_rs2data <= '0;
                r_imm     <= '0;
            end else begin
                r_valid   <= id_valid_i;
                r_ctrl    <= w_id_ctrl;
                r_funct   <= id_funct_i;
                r_rs1     <= id_rs1_i;
                r_rs2     <= id_rs2_i;
                r_rd      <= id_rd_i;
                r_rs1data <= id_rs1data_i;
                r_rs2data <= id_rs2data_i;
                r_imm     <= id_imm_i;
            end
        end
    end

`ifdef ID_EX_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!hold_i) begin
            r_stall_cnt <= r_stall_cnt + {31'd0, w_stall};
            r_flush_cnt <= r_flush_cnt + {31'd0, flush_i};
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

    assign ex_valid_o    = r_valid;
    assign ex_regwrite_o = r_ctrl.regwrite;
    assign ex_memtoreg_o = r_ctrl.memtoreg;
    assign ex_memread_o  = r_ctrl.memread;
    assign ex_memwrite_o = r_ctrl.memwrite;
    assign ex_alusrc_o   = r_ctrl.alusrc;
    assign ex_aluop_o    = r_ctrl.aluop;
    assign ex_funct_o    = r_funct;
    assign ex_rs1_o      = r_rs1;
    assign ex_rs2_o      = r_rs2;
    assign ex_rd_o       = r_rd;
    assign ex_rs1data_o  = r_rs1data;
    assign ex_rs2data_o  = r_rs2data;
    assign ex_imm_o      = r_imm;
    assign stall_o       = w_stall;
endmodule
